// File: rtl/ecall_io_unit.sv
// Environment-call service unit: decodes the ECALL service number, drives board I/O,
// stalls the pipeline while busy and writes a0 back for the read-int service.
module ecall_io_unit #(
  parameter int SW_W      = 16,
  parameter int LED_W     = 16,
  parameter int DB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ecall_valid,
  input  logic [31:0]       a7_data,
  input  logic [31:0]       a0_data,
  input  logic [SW_W-1:0]   switch_data,
  input  logic              conf_btn,
  output logic              stall,
  output logic              reg_write,
  output logic [4:0]        reg_waddr,
  output logic [31:0]       reg_wdata,
  output logic [31:0]       seg_data,
  output logic [LED_W-1:0]  led_data,
  output logic              halt,
  output logic              ecall_done
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, EXEC, WAIT_REL, WAIT_PRESS, WRITE, DONE, HALT
  } state_t;

  state_t           state;
  logic             btn_p0, btn_p1;
  logic             btn_stable, press;
  logic [CNT_W-1:0] db_cnt;
  logic [31:0]      svc, arg;

  // Synchronizer (p0/p1) then debounce; press pulses for one cycle on a stable 0->1 flip.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_p0     <= 1'b0;
      btn_p1     <= 1'b0;
      btn_stable <= 1'b0;
      db_cnt     <= '0;
      press      <= 1'b0;
    end else begin
      btn_p0 <= conf_btn;
      btn_p1 <= btn_p0;
      press  <= 1'b0;
      if (btn_p1 != btn_stable) begin
        if (db_cnt == CNT_LAST) begin
          btn_stable <= btn_p1;
          db_cnt     <= '0;
          press      <= btn_p1;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Service FSM; reg_write and ecall_done are raised on entry to WRITE and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      seg_data   <= '0;
      led_data   <= '0;
      halt       <= 1'b0;
      reg_write  <= 1'b0;
      reg_wdata  <= '0;
      ecall_done <= 1'b0;
    end else begin
      reg_write  <= 1'b0;
      ecall_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ecall_valid) begin
            svc   <= a7_data;
            arg   <= a0_data;
            state <= EXEC;
          end
        end
        EXEC: begin
          case (svc)
            32'd1: begin
              seg_data   <= arg;
              ecall_done <= 1'b1;
              state      <= DONE;
            end
            32'd34: begin
              led_data   <= arg[LED_W-1:0];
              ecall_done <= 1'b1;
              state      <= DONE;
            end
            32'd5:  state <= WAIT_REL;
            32'd10: begin
              halt  <= 1'b1;
              state <= HALT;
            end
            default: begin
              ecall_done <= 1'b1;
              state      <= DONE;
            end
          endcase
        end
        WAIT_REL: begin
          // A button still held from an earlier read must be released first.
          if (!btn_stable) state <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (press) begin
            reg_wdata <= 32'(switch_data);
            reg_write <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          ecall_done <= 1'b1;
          state      <= DONE;
        end
        DONE:    state <= IDLE;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall     = (state == IDLE) ? ecall_valid : (state != DONE);
  assign reg_waddr = 5'd10;

endmodule

// File: tb/tb_ecall_io_unit.sv
// Randomized bench for ecall_io_unit: service-level reference model of seg/led/halt
// state, read write-back contents and timing windows.
module tb_ecall_io_unit;
  localparam int SW_W  = 16;
  localparam int LED_W = 16;
  localparam int DB    = 16;

  logic              clk = 1'b0;
  logic              rst, ecall_valid, conf_btn;
  logic [31:0]       a7_data, a0_data;
  logic [SW_W-1:0]   switch_data;
  logic              stall, reg_write, halt, ecall_done;
  logic [4:0]        reg_waddr;
  logic [31:0]       reg_wdata, seg_data;
  logic [LED_W-1:0]  led_data;

  ecall_io_unit #(.SW_W(SW_W), .LED_W(LED_W), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .ecall_valid(ecall_valid), .a7_data(a7_data),
    .a0_data(a0_data), .switch_data(switch_data), .conf_btn(conf_btn),
    .stall(stall), .reg_write(reg_write), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .seg_data(seg_data), .led_data(led_data),
    .halt(halt), .ecall_done(ecall_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, wr_cnt = 0, wr_cyc = -1, done_cyc = -1;
  logic [31:0]      wr_data, wr_exp;
  logic [SW_W-1:0]  sw_hist [0:8191];
  logic             s_stall, s_done, s_halt, s_write;
  logic [31:0]      s_seg, s_wdata;
  logic [LED_W-1:0] s_led;
  logic [31:0]      exp_seg = '0;
  logic [LED_W-1:0] exp_led = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sample this cycle's outputs on the falling edge, then move to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    sw_hist[cyc % 8192] = switch_data;
    s_stall = stall;
    s_done  = ecall_done;
    s_halt  = halt;
    s_write = reg_write;
    s_seg   = seg_data;
    s_led   = led_data;
    s_wdata = reg_wdata;
    chk("waddr", 32'(reg_waddr), 32'd10);
    if (reg_write === 1'b1) begin
      wr_cnt++;
      wr_cyc  = cyc;
      wr_data = reg_wdata;
      wr_exp  = 32'(sw_hist[(cyc + 8191) % 8192]);
    end
    if (ecall_done === 1'b1) done_cyc = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic simple(input logic [31:0] a7, input logic [31:0] a0);
    int w0;
    w0 = wr_cnt;
    ecall_valid = 1'b1;
    a7_data = a7;
    a0_data = a0;
    step();
    chk("stall_c0", 32'(s_stall), 1);
    chk("done_c0", 32'(s_done), 0);
    a7_data = $urandom;
    a0_data = $urandom;
    step();
    chk("stall_c1", 32'(s_stall), 1);
    chk("done_c1", 32'(s_done), 0);
    chk("seg_c1", s_seg, exp_seg);
    if (a7 == 32'd1)  exp_seg = a0;
    if (a7 == 32'd34) exp_led = a0[LED_W-1:0];
    step();
    chk("done_c2", 32'(s_done), 1);
    chk("stall_c2", 32'(s_stall), 0);
    chk("seg_c2", s_seg, exp_seg);
    chk("led_c2", 32'(s_led), 32'(exp_led));
    chk("no_wr_simple", 32'(wr_cnt), 32'(w0));
    ecall_valid = 1'b0;
    step();
    chk("done_c3", 32'(s_done), 0);
  endtask

  task automatic read_svc(input bit held, input bit glitch, input bit fixed_sw);
    int w0, d0, pstart, t;
    if (held) begin
      conf_btn = 1'b1;
      repeat (DB + 5) step();
    end
    w0 = wr_cnt;
    d0 = done_cyc;
    ecall_valid = 1'b1;
    a7_data = 32'd5;
    a0_data = $urandom;
    switch_data = fixed_sw ? 16'h00A5 : 16'($urandom);
    repeat (DB + 6) step();
    chk("held_nowr", 32'(wr_cnt), 32'(w0));
    chk("held_stall", 32'(s_stall), 1);
    chk("held_nodone", 32'(done_cyc), 32'(d0));
    conf_btn = 1'b0;
    repeat (DB + 3) step();
    if (glitch) begin
      conf_btn = 1'b1;
      repeat (5) step();
      conf_btn = 1'b0;
      repeat (DB + 3) step();
      chk("glitch_nowr", 32'(wr_cnt), 32'(w0));
    end
    conf_btn = 1'b1;
    pstart = cyc;
    t = 0;
    s_done = 1'b0;
    while (!s_done && t < DB + 12) begin
      if (!fixed_sw) switch_data = 16'($urandom);
      step();
      t++;
    end
    if (!s_done) begin
      chk("read_timeout", 32'd0, 32'd1);
    end else begin
      chk("wr_count", 32'(wr_cnt - w0), 32'd1);
      chk("wr_data", wr_data, fixed_sw ? 32'h000000A5 : wr_exp);
      chk("wr_window", 32'((wr_cyc >= pstart + DB) && (wr_cyc <= pstart + DB + 4)), 32'd1);
      chk("done_after_wr", 32'(done_cyc), 32'(wr_cyc + 1));
      chk("stall_done", 32'(s_stall), 0);
    end
    ecall_valid = 1'b0;
    step();
    chk("seg_kept", s_seg, exp_seg);
    if ($urandom % 2 == 0) begin
      conf_btn = 1'b0;
      repeat (DB + 3) step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, d0, r;
    rst = 1'b1; ecall_valid = 1'b0; conf_btn = 1'b0;
    a7_data = '0; a0_data = '0; switch_data = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_seg", s_seg, 0);
    chk("rst_led", 32'(s_led), 0);
    chk("rst_halt", 32'(s_halt), 0);
    chk("rst_write", 32'(s_write), 0);
    chk("rst_wdata", s_wdata, 0);
    chk("rst_done", 32'(s_done), 0);
    chk("rst_stall", 32'(s_stall), 0);
    repeat (10) begin
      step();
      chk("idle_stall", 32'(s_stall), 0);
    end
    chk("idle_nowr", 32'(wr_cnt), 0);

    simple(32'd1, 32'hDEADBEEF);
    chk("print_seg", s_seg, 32'hDEADBEEF);
    read_svc(1'b1, 1'b1, 1'b1);
    simple(32'd34, 32'h1234ABCD);
    chk("led_abcd", 32'(s_led), 32'h0000ABCD);
    simple(32'd99, 32'h55555555);

    for (int i = 0; i < 20; i++) begin
      r = $urandom % 4;
      case (r)
        0: simple(32'd1, $urandom);
        1: simple(32'd34, $urandom);
        2: simple(($urandom % 2) ? 32'd99 : 32'($urandom_range(11, 33)), $urandom);
        default: read_svc(1'($urandom % 2), 1'($urandom % 2), 1'b0);
      endcase
    end

    conf_btn = 1'b0;
    repeat (DB + 3) step();
    d0 = done_cyc;
    ecall_valid = 1'b1;
    a7_data = 32'd10;
    a0_data = $urandom;
    step();
    chk("exit_stall_c0", 32'(s_stall), 1);
    step();
    chk("exit_stall_c1", 32'(s_stall), 1);
    repeat (55) begin
      step();
      chk("exit_halt", 32'(s_halt), 1);
      chk("exit_stall", 32'(s_stall), 1);
    end
    chk("exit_nodone", 32'(done_cyc), 32'(d0));
    rst = 1'b1;
    ecall_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_seg = '0;
    exp_led = '0;
    step();
    chk("exit_rst_halt", 32'(s_halt), 0);
    chk("exit_rst_stall", 32'(s_stall), 0);
    chk("exit_rst_seg", s_seg, 0);

    w0 = wr_cnt;
    d0 = done_cyc;
    ecall_valid = 1'b1;
    a7_data = 32'd5;
    a0_data = $urandom;
    repeat (DB + 6) step();
    chk("mid_stall", 32'(s_stall), 1);
    rst = 1'b1;
    ecall_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_stall", 32'(s_stall), 0);
    conf_btn = 1'b1;
    repeat (DB + 6) step();
    chk("mid_rst_nowr", 32'(wr_cnt), 32'(w0));
    chk("mid_rst_nodone", 32'(done_cyc), 32'(d0));
    chk("mid_rst_stall2", 32'(s_stall), 0);
    conf_btn = 1'b0;
    repeat (DB + 3) step();
    simple(32'd1, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ecall_io_unit.md
Name: ecall_io_unit

Overview:
- Environment-call service unit, sitting between the decode stage and the register file.
- On a decoded ECALL it consumes the register-file a7/a0 taps and performs the board I/O service selected by a7. It drives the 7-seg/LED outputs, stalls the pipeline while the service runs, and for read-type services produces the a0 write-back (write enable, address, data) into the register file's write port.
- Handles the confirm-button handshake for user input, including debounce.

Parameters:
- SW_W, 16, switch input width (1..32); read value is zero-extended to 32 bits.
- LED_W, 16, LED output width (1..32).
- DB_CYCLES, 16, consecutive stable cycles needed before a button level change is accepted. Board builds override to 1_000_000; simulation keeps 16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ecall_valid  in  1  decode holds an ECALL; held high until the cycle after ecall_done.
- a7_data  in  32  register x17 (service number).
- a0_data  in  32  register x10 (argument).
- switch_data  in  SW_W  board switches.
- conf_btn  in  1  raw confirm button, asynchronous to clk.
- stall  out  1  freezes PC/fetch/decode when high.
- reg_write  out  1  write enable to the register file.
- reg_waddr  out  5  write address; always 5'd10.
- reg_wdata  out  32  write data.
- seg_data  out  32  value shown on the 7-seg display.
- led_data  out  LED_W  LED value.
- halt  out  1  program exited; sticky until reset.
- ecall_done  out  1  one-cycle pulse: service complete.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - State goes to IDLE.
  - Outputs cleared: seg_data=0, led_data=0, halt=0, reg_write=0, reg_wdata=0, ecall_done=0, stall=0.
  - Debounce state cleared; stable button level = 0.
  - Reset wins over every other event, including mid-service. No reg_write is issued for an aborted service.
- conf_btn path:
  - Two-flop synchronizer, then debounce. The counter increments while the synchronized level differs from the stable level and clears when they match.
  - When the counter reaches DB_CYCLES-1 the stable level flips and the counter clears.
  - A press is a 0->1 transition of the stable level.
- States: IDLE, EXEC, WAIT_REL, WAIT_PRESS, WRITE, DONE, HALT.
  - IDLE: if ecall_valid, latch a7_data and a0_data, then go to EXEC.
  - EXEC: dispatch on the latched a7:
    - 1 (print int): seg_data <= a0, then DONE.
    - 34 (LED write): led_data <= a0[LED_W-1:0], then DONE.
    - 5 (read int): go to WAIT_REL.
    - 10 (exit): halt <= 1, then HALT.
    - Any other value: no side effect, then DONE.
  - WAIT_REL: stay until the stable button level is 0, then WAIT_PRESS. This blocks a press that was held from a previous read.
  - WAIT_PRESS: on a press, capture {zeros, switch_data} into reg_wdata, then WRITE.
  - WRITE: reg_write=1 for exactly this cycle, reg_waddr=10. Then DONE.
  - DONE: ecall_done=1, stall=0, then IDLE.
  - HALT: absorbing state; only rst leaves it.
- stall (combinational):
  - High in IDLE when ecall_valid=1.
  - High in EXEC, WAIT_REL, WAIT_PRESS, WRITE and HALT.
  - Low in DONE, and in IDLE when no ECALL is pending.
- Latency from ecall_valid rising in IDLE (cycle 0):
  - Print/LED/unknown services: side effect visible from cycle 2. ecall_done and stall=0 in cycle 2. Total 2 stall cycles (0 and 1).
  - Read service: minimum is 2 + debounce time + 2 cycles after the physical press.
- Back-to-back ECALLs:
  - In the DONE cycle the CPU advances the PC. An ECALL decoded in the next cycle is seen in IDLE as a new request.
  - ecall_valid high in DONE is ignored.
- Outside the WRITE state: reg_write=0, and reg_waddr stays 10.
- switch_data may change freely; only its value in the press cycle is used.
- seg_data and led_data hold their values until the next matching service or reset.

Test Plan:
- Reset then idle: rst high 2 cycles -> all outputs 0. ecall_valid=0 for 10 cycles -> stall stays 0, reg_write never pulses.
- Print: a7=1, a0=32'hDEADBEEF, ecall_valid at cycle 0 -> stall=1 in cycles 0-1. In cycle 2: seg_data=32'hDEADBEEF, ecall_done=1, stall=0.
- Read with held button: conf_btn already high at ECALL, a7=5, switches=16'h00A5 -> no write while the button is held. Release for DB_CYCLES+3 cycles, press for DB_CYCLES+3 cycles -> exactly one reg_write pulse with waddr=10, wdata=32'h000000A5, then ecall_done next cycle. A 5-cycle glitch press before the real press is rejected.
- LED and unknown: a7=34, a0=32'h1234ABCD -> led_data=16'hABCD, done at cycle 2. a7=99 -> done at cycle 2 with seg/led unchanged.
- Exit and reset mid-read: a7=10 -> halt=1 and stall=1 for 50+ cycles, ecall_done never pulses; then rst -> halt=0. Next, start a read and assert rst while in WAIT_PRESS -> state IDLE, no reg_write, stall=0.
